// File: rtl/pipeline_hazard_controller_if.sv
// Decode-side hazard control bundle: ID/EX hazard inputs, pipeline enables/flushes,
// the multi-cycle start handshake and the controller's debug state.
interface pipeline_hazard_controller_if;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_rs1_used;
    logic        ID_rs2_used;
    logic [4:0]  EX_RegDst;
    logic        EX_MemRead;
    logic        EX_is_mc;
    logic        Redirect;
    logic        MC_done;
    logic        PC_write;
    logic        IF_ID_write;
    logic        IF_ID_flush;
    logic        ID_EX_hold;
    logic        ID_EX_bubble;
    logic        EX_MEM_bubble;
    logic        MC_start;
    logic        MC_timeout;
    logic [31:0] Stall_cycles;
    logic [1:0]  state_dbg;

    // MC_start is a single-cycle pulse; MC_done is the unit's single-cycle completion pulse.
    modport master (
        output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_RegDst, EX_MemRead,
               EX_is_mc, Redirect, MC_done,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_hold, ID_EX_bubble,
               EX_MEM_bubble, MC_start, MC_timeout, Stall_cycles, state_dbg
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_RegDst, EX_MemRead,
               EX_is_mc, Redirect, MC_done,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_hold, ID_EX_bubble,
               EX_MEM_bubble, MC_start, MC_timeout, Stall_cycles, state_dbg
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// ID/EX hazard sequencer: load-use stalls, redirect flush/drain, and multi-cycle EX hold
// with a watchdog. Outputs are combinational from state and inputs.
module pipeline_hazard_controller #(
    parameter int unsigned REDIRECT_PENALTY = 0,
    parameter int unsigned MC_TIMEOUT       = 64
) (
    input  logic                         CLK,
    input  logic                         RESET,
    pipeline_hazard_controller_if.slave  bus
);
    localparam int WDOG_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(MC_TIMEOUT);
    localparam logic [3:0]        PENALTY  = 4'(REDIRECT_PENALTY);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MC_WAIT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [WDOG_W-1:0] wdog;
    logic              mc_timeout_q;
    logic [31:0]       stall_q;

    logic load_use;
    logic pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_bubble, mc_start;

    // Writes to x0 never create a dependency.
    always_comb begin
        load_use = bus.EX_MemRead && (bus.EX_RegDst != 5'd0) &&
                   ((bus.ID_rs1_used && (bus.ID_rs1 == bus.EX_RegDst)) ||
                    (bus.ID_rs2_used && (bus.ID_rs2 == bus.EX_RegDst)));
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mc_start      = 1'b0;
        if (RESET) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    if (bus.Redirect) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (bus.EX_is_mc) begin
                        mc_start      = 1'b1;
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_hold    = 1'b1;
                        ex_mem_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                S_MC_WAIT: begin
                    // On MC_done the pipeline resumes this cycle, so a pending load-use still applies.
                    if (bus.MC_done) begin
                        if (load_use) begin
                            pc_write     = 1'b0;
                            if_id_write  = 1'b0;
                            id_ex_bubble = 1'b1;
                        end
                    end else begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_hold    = 1'b1;
                        ex_mem_bubble = 1'b1;
                    end
                end
                S_DRAIN: begin
                    pc_write     = bus.Redirect;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_RUN;
            cnt          <= 4'd0;
            wdog         <= '0;
            mc_timeout_q <= 1'b0;
            stall_q      <= 32'd0;
        end else begin
            if (!pc_write) stall_q <= stall_q + 32'd1;
            case (state)
                S_RUN: begin
                    if (bus.Redirect) begin
                        if (PENALTY != 4'd0) begin
                            state <= S_DRAIN;
                            cnt   <= PENALTY;
                        end
                    end else if (bus.EX_is_mc) begin
                        state <= S_MC_WAIT;
                        wdog  <= WDOG_W'(1);
                    end
                end
                S_MC_WAIT: begin
                    if (wdog != WDOG_MAX) wdog <= wdog + WDOG_W'(1);
                    if (bus.MC_done) state <= S_RUN;
                    else if (wdog == WDOG_MAX) mc_timeout_q <= 1'b1;
                end
                S_DRAIN: begin
                    if (bus.Redirect) begin
                        cnt <= PENALTY;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= S_RUN;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign bus.PC_write      = pc_write;
    assign bus.IF_ID_write   = if_id_write;
    assign bus.IF_ID_flush   = if_id_flush;
    assign bus.ID_EX_hold    = id_ex_hold;
    assign bus.ID_EX_bubble  = id_ex_bubble;
    assign bus.EX_MEM_bubble = ex_mem_bubble;
    assign bus.MC_start      = mc_start;
    assign bus.MC_timeout    = mc_timeout_q;
    assign bus.Stall_cycles  = stall_q;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: dut_a (penalty 2, timeout 64) runs a per-cycle vector table; dut_b
// (penalty 0, timeout 4) shares the stimulus and covers watchdog and zero-penalty redirect.
module tb_pipeline_hazard_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Control vector: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_hold, ID_EX_bubble, EX_MEM_bubble, MC_start}
    localparam logic [6:0] C_DEF = 7'b1100000;
    localparam logic [6:0] C_RST = 7'b0010100;
    localparam logic [6:0] C_LU  = 7'b0000100;
    localparam logic [6:0] C_RDR = 7'b1110100;
    localparam logic [6:0] C_MCS = 7'b0001011;
    localparam logic [6:0] C_MCW = 7'b0001010;
    localparam logic [6:0] C_DRN = 7'b0110100;
    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_MCW = 2'd1;
    localparam logic [1:0] ST_DRN = 2'd2;

    pipeline_hazard_controller_if bus_a ();
    pipeline_hazard_controller_if bus_b ();

    assign bus_b.ID_rs1      = bus_a.ID_rs1;
    assign bus_b.ID_rs2      = bus_a.ID_rs2;
    assign bus_b.ID_rs1_used = bus_a.ID_rs1_used;
    assign bus_b.ID_rs2_used = bus_a.ID_rs2_used;
    assign bus_b.EX_RegDst   = bus_a.EX_RegDst;
    assign bus_b.EX_MemRead  = bus_a.EX_MemRead;
    assign bus_b.EX_is_mc    = bus_a.EX_is_mc;
    assign bus_b.Redirect    = bus_a.Redirect;
    assign bus_b.MC_done     = bus_a.MC_done;

    pipeline_hazard_controller #(.REDIRECT_PENALTY(2), .MC_TIMEOUT(64)) dut_a (
        .CLK(clk), .RESET(rst), .bus(bus_a.slave));
    pipeline_hazard_controller #(.REDIRECT_PENALTY(0), .MC_TIMEOUT(4)) dut_b (
        .CLK(clk), .RESET(rst), .bus(bus_b.slave));

    logic [6:0] ctrl_a, ctrl_b;
    assign ctrl_a = {bus_a.PC_write, bus_a.IF_ID_write, bus_a.IF_ID_flush, bus_a.ID_EX_hold,
                     bus_a.ID_EX_bubble, bus_a.EX_MEM_bubble, bus_a.MC_start};
    assign ctrl_b = {bus_b.PC_write, bus_b.IF_ID_write, bus_b.IF_ID_flush, bus_b.ID_EX_hold,
                     bus_b.ID_EX_bubble, bus_b.EX_MEM_bubble, bus_b.MC_start};

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic       rs1_used;
        logic [4:0] rs2;
        logic       rs2_used;
        logic [4:0] rd;
        logic       mem_read;
        logic       is_mc;
        logic       redirect;
        logic       mc_done;
        logic [6:0] exp_ctrl;
        logic [1:0] exp_state;
    } vec_t;

    vec_t       vq[$];
    logic [6:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [31:0] exp_stall = 32'd0;

    function automatic vec_t mkv(input logic r, input logic [4:0] rs1, input logic rs1u,
                                 input logic [4:0] rs2, input logic rs2u, input logic [4:0] rd,
                                 input logic mr, input logic mc, input logic rdr, input logic done,
                                 input logic [6:0] c, input logic [1:0] st);
        vec_t v;
        v.rst = r; v.rs1 = rs1; v.rs1_used = rs1u; v.rs2 = rs2; v.rs2_used = rs2u;
        v.rd = rd; v.mem_read = mr; v.is_mc = mc; v.redirect = rdr; v.mc_done = done;
        v.exp_ctrl = c; v.exp_state = st;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vq.push_back(v);
        exp_q.push_back(v.exp_ctrl);
    endtask

    task automatic apply(input vec_t v);
        rst               = v.rst;
        bus_a.ID_rs1      = v.rs1;
        bus_a.ID_rs1_used = v.rs1_used;
        bus_a.ID_rs2      = v.rs2;
        bus_a.ID_rs2_used = v.rs2_used;
        bus_a.EX_RegDst   = v.rd;
        bus_a.EX_MemRead  = v.mem_read;
        bus_a.EX_is_mc    = v.is_mc;
        bus_a.Redirect    = v.redirect;
        bus_a.MC_done     = v.mc_done;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1 apply(v);
        @(negedge clk);
    endtask

    initial begin
        // Per-cycle table: rst, rs1, rs1u, rs2, rs2u, rd, memrd, is_mc, redirect, mc_done, ctrl, state
        add(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, ST_RUN));  // 0 reset
        add(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, ST_RUN));  // 1 reset
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));  // 2 first cycle after release
        add(mkv(0, 0, 0, 5, 1, 5, 1, 0, 0, 0, C_LU,  ST_RUN));  // 3 load-use on rs2
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));  // 4 single-cycle stall only
        add(mkv(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, C_DEF, ST_RUN));  // 5 load to x0: no stall
        add(mkv(0, 7, 0, 7, 0, 7, 1, 0, 0, 0, C_DEF, ST_RUN));  // 6 match but regs unused
        add(mkv(0, 9, 1, 0, 0, 9, 1, 0, 0, 0, C_LU,  ST_RUN));  // 7 load-use on rs1
        add(mkv(0, 9, 1, 0, 0, 9, 0, 0, 0, 0, C_DEF, ST_RUN));  // 8 not a load
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RDR, ST_RUN));  // 9 redirect
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRN, ST_DRN));  // 10
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRN, ST_DRN));  // 11
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));  // 12
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RDR, ST_RUN));  // 13 redirect
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRN, ST_DRN));  // 14
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RDR, ST_DRN));  // 15 redirect restarts drain
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRN, ST_DRN));  // 16
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRN, ST_DRN));  // 17
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));  // 18
        add(mkv(0, 0, 0, 5, 1, 5, 1, 1, 1, 0, C_RDR, ST_RUN));  // 19 redirect beats mc and load-use
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRN, ST_DRN));  // 20
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRN, ST_DRN));  // 21
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));  // 22
        add(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MCS, ST_RUN));  // 23 mc start
        add(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MCW, ST_MCW));  // 24 redirect ignored
        add(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MCW, ST_MCW));  // 25
        add(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MCW, ST_MCW));  // 26
        add(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MCW, ST_MCW));  // 27
        add(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_DEF, ST_MCW));  // 28 done: released
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));  // 29
        add(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MCS, ST_RUN));  // 30 mc start
        add(mkv(0, 5, 1, 0, 0, 5, 1, 0, 0, 1, C_LU,  ST_MCW));  // 31 done with load-use pending
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));  // 32
        add(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MCS, ST_RUN));  // 33 mc start
        add(mkv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RST, ST_MCW));  // 34 reset aborts mc wait
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));  // 35
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RDR, ST_RUN));  // 36 redirect
        add(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, ST_DRN));  // 37 reset aborts drain
        add(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));  // 38

        apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, ST_RUN));

        for (int i = 0; i < vq.size(); i++) begin
            logic [6:0] exp_c;
            step(vq[i]);
            exp_c = exp_q.pop_front();
            chk("ctrl_a", i, 32'(ctrl_a), 32'(exp_c));
            chk("state_a", i, 32'(bus_a.state_dbg), 32'(vq[i].exp_state));
            chk("stall_a", i, bus_a.Stall_cycles, exp_stall);
            if (vq[i].rst) exp_stall = 32'd0;
            else if (!exp_c[6]) exp_stall = exp_stall + 32'd1;
        end
        chk("timeout_a", 0, 32'(bus_a.MC_timeout), 32'd0);

        // Watchdog on dut_b: no MC_done ever arrives.
        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, ST_RUN));
        step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MCS, ST_RUN));
        chk("mc_start_b", 0, 32'(ctrl_b), 32'(C_MCS));
        for (int k = 1; k <= 4; k++) begin
            step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MCW, ST_MCW));
            chk("wait_ctrl_b", k, 32'(ctrl_b), 32'(C_MCW));
            chk("pre_timeout_b", k, 32'(bus_b.MC_timeout), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MCW, ST_MCW));
            chk("timeout_b", k, 32'(bus_b.MC_timeout), 32'd1);
            chk("timeout_state_b", k, 32'(bus_b.state_dbg), 32'(ST_MCW));
            chk("timeout_ctrl_b", k, 32'(ctrl_b), 32'(C_MCW));
        end
        chk("no_timeout_a", 0, 32'(bus_a.MC_timeout), 32'd0);
        step(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, ST_RUN));
        chk("rst_ctrl_b", 0, 32'(ctrl_b), 32'(C_RST));
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));
        chk("timeout_clr_b", 0, 32'(bus_b.MC_timeout), 32'd0);
        chk("rst_state_b", 0, 32'(bus_b.state_dbg), 32'(ST_RUN));
        chk("rst_run_b", 0, 32'(ctrl_b), 32'(C_DEF));

        // Zero-penalty redirect on dut_b: flush one cycle, no drain.
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RDR, ST_RUN));
        chk("rdr0_b", 0, 32'(ctrl_b), 32'(C_RDR));
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, ST_RUN));
        chk("rdr0_next_b", 0, 32'(ctrl_b), 32'(C_DEF));
        chk("rdr0_state_b", 0, 32'(bus_b.state_dbg), 32'(ST_RUN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
